// File: rtl/vscale_dmem_arbiter.sv
// Two-master arbiter for the vscale data-memory port: pipelined address/data phases.
// Optional starvation guard for master 1 is enabled by defining VSCALE_DMEM_ARB_STARVE_EN.
module vscale_dmem_arbiter #(
    parameter int STARVE_MAX     = 8,
    parameter int XPR_LEN        = 32,
    parameter int MEM_TYPE_WIDTH = 3
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      m0_en,
    input  logic                      m0_wen,
    input  logic [MEM_TYPE_WIDTH-1:0] m0_size,
    input  logic [XPR_LEN-1:0]        m0_addr,
    input  logic [XPR_LEN-1:0]        m0_wdata,
    output logic                      m0_wait,
    output logic                      m0_badmem_e,
    input  logic                      m1_en,
    input  logic                      m1_wen,
    input  logic [MEM_TYPE_WIDTH-1:0] m1_size,
    input  logic [XPR_LEN-1:0]        m1_addr,
    input  logic [XPR_LEN-1:0]        m1_wdata,
    output logic                      m1_wait,
    output logic                      m1_badmem_e,
    output logic [XPR_LEN-1:0]        rdata,
    output logic                      s_en,
    output logic                      s_wen,
    output logic [MEM_TYPE_WIDTH-1:0] s_size,
    output logic [XPR_LEN-1:0]        s_addr,
    output logic [XPR_LEN-1:0]        s_wdata,
    input  logic [XPR_LEN-1:0]        s_rdata,
    input  logic                      s_wait,
    input  logic                      s_badmem_e
);

    if (STARVE_MAX < 1 || STARVE_MAX > 255) begin : g_bad_starve_max
        $error("vscale_dmem_arbiter: STARVE_MAX out of range 1..255");
    end

    logic dp_valid;
    logic dp_owner;
    logic gnt_q;
    logic gnt;
    logic ready;
    logic accept;
    logic force_m1;

    assign ready = ~(dp_valid & s_wait);

    always_comb begin
        gnt = gnt_q;
        if (ready) begin
            if (m1_en && force_m1) begin
                gnt = 1'b1;
            end else if (m0_en) begin
                gnt = 1'b0;
            end else if (m1_en) begin
                gnt = 1'b1;
            end
        end
    end

    // Address fields are zeroed while idle so an idle port shows no stale address.
    assign s_en   = gnt ? m1_en : m0_en;
    assign s_wen  = s_en & (gnt ? m1_wen : m0_wen);
    assign s_size = s_en ? (gnt ? m1_size : m0_size) : '0;
    assign s_addr = s_en ? (gnt ? m1_addr : m0_addr) : '0;
    assign accept = s_en & ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dp_valid <= 1'b0;
            dp_owner <= 1'b0;
            gnt_q    <= 1'b0;
        end else begin
            gnt_q <= gnt;
            if (accept) begin
                dp_valid <= 1'b1;
                dp_owner <= gnt;
            end else if (ready) begin
                dp_valid <= 1'b0;
            end
        end
    end

`ifdef VSCALE_DMEM_ARB_STARVE_EN
    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIMIT = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt <= '0;
        end else if (ready) begin
            if (accept && gnt) begin
                starve_cnt <= '0;
            end else if (m1_en && !gnt && starve_cnt != STARVE_LIMIT) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

    assign force_m1 = (starve_cnt == STARVE_LIMIT);
`else
    assign force_m1 = 1'b0;
`endif

    assign s_wdata = dp_valid ? (dp_owner ? m1_wdata : m0_wdata) : '0;
    assign rdata   = s_rdata;

    assign m0_badmem_e = s_badmem_e & dp_valid & ~dp_owner;
    assign m1_badmem_e = s_badmem_e & dp_valid &  dp_owner;

    // A master stalls on its own slow data phase or on an address phase it cannot issue yet.
    assign m0_wait = (dp_valid & ~dp_owner & s_wait) | (m0_en & (gnt  | ~ready));
    assign m1_wait = (dp_valid &  dp_owner & s_wait) | (m1_en & (~gnt | ~ready));

endmodule

// File: tb/tb_vscale_dmem_arbiter.sv
// Self-checking bench for vscale_dmem_arbiter: directed scenarios plus random traffic
// compared each cycle against a transaction-level reference model.
module tb_vscale_dmem_arbiter;
    localparam int XL   = 32;
    localparam int MW   = 3;
    localparam int SMAX = 8;
`ifdef VSCALE_DMEM_ARB_STARVE_EN
    localparam bit STARVE_ON = 1'b1;
`else
    localparam bit STARVE_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic          m0_en, m0_wen, m1_en, m1_wen;
    logic [MW-1:0] m0_size, m1_size;
    logic [XL-1:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic          m0_wait, m0_badmem_e, m1_wait, m1_badmem_e;
    logic [XL-1:0] rdata;
    logic          s_en, s_wen;
    logic [MW-1:0] s_size;
    logic [XL-1:0] s_addr, s_wdata, s_rdata;
    logic          s_wait, s_badmem_e;

    int checks   = 0;
    int failures = 0;

    vscale_dmem_arbiter #(.STARVE_MAX(SMAX), .XPR_LEN(XL), .MEM_TYPE_WIDTH(MW)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_en(m0_en), .m0_wen(m0_wen), .m0_size(m0_size), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_wait(m0_wait), .m0_badmem_e(m0_badmem_e),
        .m1_en(m1_en), .m1_wen(m1_wen), .m1_size(m1_size), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_wait(m1_wait), .m1_badmem_e(m1_badmem_e),
        .rdata(rdata), .s_en(s_en), .s_wen(s_wen), .s_size(s_size), .s_addr(s_addr),
        .s_wdata(s_wdata), .s_rdata(s_rdata), .s_wait(s_wait), .s_badmem_e(s_badmem_e)
    );

    always #5 clk = ~clk;

    // Reference model: queue of outstanding data-phase owners, last winner, loss count.
    int pend_q[$];
    int last_gnt = 0;
    int starve   = 0;
    int nxt_owner, nxt_last, nxt_starve;
    bit nxt_pend;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pend_q.delete();
        last_gnt = 0;
        starve   = 0;
    endtask

    // Called just after a rising edge with inputs set; checks outputs mid-cycle.
    task automatic settle();
        bit pend, busy, acc;
        int owner, win;
        logic          e_en;
        logic [XL-1:0] e_addr, e_wd;
        logic [MW-1:0] e_size;
        #3;
        if (!reset_n) model_reset();
        pend  = (pend_q.size() != 0);
        owner = pend ? pend_q[0] : 0;
        busy  = pend && s_wait;
        if (busy)                                        win = last_gnt;
        else if (m1_en && STARVE_ON && starve >= SMAX)   win = 1;
        else if (m0_en)                                  win = 0;
        else if (m1_en)                                  win = 1;
        else                                             win = last_gnt;
        e_en   = (win == 1) ? m1_en : m0_en;
        e_addr = !e_en ? '0 : ((win == 1) ? m1_addr : m0_addr);
        e_size = !e_en ? '0 : ((win == 1) ? m1_size : m0_size);
        e_wd   = !pend ? '0 : ((owner == 1) ? m1_wdata : m0_wdata);
        check("s_en",    32'(s_en),    32'(e_en));
        check("s_wen",   32'(s_wen),   32'(e_en && ((win == 1) ? m1_wen : m0_wen)));
        check("s_size",  32'(s_size),  32'(e_size));
        check("s_addr",  s_addr,       e_addr);
        check("s_wdata", s_wdata,      e_wd);
        check("rdata",   rdata,        s_rdata);
        check("m0_badmem", 32'(m0_badmem_e), 32'(s_badmem_e && pend && owner == 0));
        check("m1_badmem", 32'(m1_badmem_e), 32'(s_badmem_e && pend && owner == 1));
        check("m0_wait", 32'(m0_wait),
              32'((pend && owner == 0 && s_wait) || (m0_en && (win != 0 || busy))));
        check("m1_wait", 32'(m1_wait),
              32'((pend && owner == 1 && s_wait) || (m1_en && (win != 1 || busy))));
        acc        = e_en && !busy;
        nxt_last   = win;
        nxt_starve = starve;
        nxt_pend   = pend;
        nxt_owner  = owner;
        if (!busy) begin
            nxt_pend = acc;
            if (acc) nxt_owner = win;
            if (acc && win == 1)            nxt_starve = 0;
            else if (m1_en && win == 0)     nxt_starve = (starve + 1 > SMAX) ? SMAX : starve + 1;
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        if (!reset_n) begin
            model_reset();
        end else begin
            pend_q.delete();
            if (nxt_pend) pend_q.push_back(nxt_owner);
            last_gnt = nxt_last;
            starve   = nxt_starve;
        end
    endtask

    task automatic idle_inputs();
        m0_en = 0; m0_wen = 0; m0_size = '0; m0_addr = '0; m0_wdata = '0;
        m1_en = 0; m1_wen = 0; m1_size = '0; m1_addr = '0; m1_wdata = '0;
        s_rdata = '0; s_wait = 0; s_badmem_e = 0;
    endtask

    task automatic random_inputs();
        m0_en = 1'($urandom_range(0, 1)); m0_wen = 1'($urandom_range(0, 1));
        m1_en = 1'($urandom_range(0, 1)); m1_wen = 1'($urandom_range(0, 1));
        m0_size = MW'($urandom); m1_size = MW'($urandom);
        m0_addr = $urandom; m1_addr = $urandom; m0_wdata = $urandom; m1_wdata = $urandom;
        s_rdata = $urandom;
        s_wait = ($urandom_range(0, 2) == 0);
        s_badmem_e = ($urandom_range(0, 3) == 0);
    endtask

    task automatic do_reset();
        reset_n = 0;
        idle_inputs();
        settle(); advance();
        reset_n = 1;
    endtask

    initial begin
        int first_m1;
        logic [XL-1:0] addr10;

        // Reset with random inputs, then release idle.
        reset_n = 0;
        #1;
        for (int i = 0; i < 3; i++) begin
            random_inputs();
            settle(); advance();
        end
        idle_inputs();
        reset_n = 1;
        settle();
        check("rst_s_en", 32'(s_en), 32'd0);
        check("rst_waits", 32'({m0_wait, m1_wait, m0_badmem_e, m1_badmem_e}), 32'd0);
        check("rst_s_addr", s_addr, 32'd0);
        advance();

        // Single master-0 load.
        m0_en = 1; m0_addr = 32'h100;
        settle();
        check("m0_ld_addr", s_addr, 32'h100);
        check("m0_ld_wait0", 32'(m0_wait), 32'd0);
        advance();
        idle_inputs(); s_rdata = 32'hDEADBEEF;
        settle();
        check("m0_ld_rdata", rdata, 32'hDEADBEEF);
        check("m0_ld_wait1", 32'(m0_wait), 32'd0);
        advance();
        idle_inputs();
        settle(); advance();

        // Contention.
        m0_en = 1; m0_addr = 32'h10; m1_en = 1; m1_addr = 32'h20;
        settle();
        check("cont_addr0", s_addr, 32'h10);
        check("cont_m1_wait", 32'(m1_wait), 32'd1);
        advance();
        m0_en = 0;
        settle();
        check("cont_addr1", s_addr, 32'h20);
        check("cont_m1_go", 32'(m1_wait), 32'd0);
        advance();
        idle_inputs();
        settle(); advance();

        // Slave wait during an m1 store while m0 requests.
        m1_en = 1; m1_wen = 1; m1_addr = 32'h40; m1_wdata = 32'h55;
        settle(); advance();
        m1_en = 0; m0_en = 1; m0_addr = 32'h80; s_wait = 1;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("sw_wdata", s_wdata, 32'h55);
            check("sw_waits", 32'({m0_wait, m1_wait}), 32'b11);
            advance();
        end
        s_wait = 0;
        settle();
        check("sw_m0_acc", 32'({s_en, m0_wait}), 32'b10);
        check("sw_m0_addr", s_addr, 32'h80);
        advance();
        idle_inputs();
        settle(); advance();

        // Starvation: both request continuously from a clean state.
        do_reset();
        first_m1 = 0; addr10 = '0;
        m0_en = 1; m0_addr = 32'h100; m1_en = 1; m1_addr = 32'h200;
        for (int k = 1; k <= 12; k++) begin
            settle();
            if (first_m1 == 0 && s_en && s_addr == 32'h200) first_m1 = k;
            if (k == 10) addr10 = s_addr;
            advance();
        end
        check("starve_first_m1", 32'(first_m1), STARVE_ON ? 32'd9 : 32'd0);
        check("starve_resume", addr10, 32'h100);
        idle_inputs();
        settle(); advance();

        // Mid-transfer reset during an m1 data phase.
        m1_en = 1; m1_wen = 1; m1_addr = 32'h300; m1_wdata = 32'h77;
        settle(); advance();
        m1_en = 0; s_wait = 1; s_badmem_e = 1;
        #3;
        check("mid_pre", 32'({m1_wait, m1_badmem_e}), 32'b11);
        reset_n = 0;
        #1;
        check("mid_post", 32'({m1_wait, m1_badmem_e}), 32'b00);
        check("mid_wdata", s_wdata, 32'd0);
        model_reset();
        @(posedge clk); #1;
        idle_inputs();
        settle(); advance();
        reset_n = 1;

        // Random traffic with occasional asynchronous resets.
        for (int i = 0; i < 600; i++) begin
            random_inputs();
            reset_n = ($urandom_range(0, 79) != 0);
            settle(); advance();
        end
        reset_n = 1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vscale_dmem_arbiter.md
# vscale_dmem_arbiter

Two-master arbiter sharing the single vscale data-memory port between the pipeline (master 0) and a secondary requester such as an HTIF loader or DMA engine (master 1). Address phases are pipelined: the data phase follows in the next cycle. The arbiter grants the address channel, tracks which master owns the outstanding data phase, and routes write data, wait and bad-memory status to that master. The pipeline's `dmem_*` ports connect to the master-0 side, and the physical memory connects to the slave side.

## Interface
- `STARVE_MAX`, default 8: consecutive lost arbitrations master 1 tolerates before it is forced to win. Legal range is 1–255.
- `clk`  in  1  clock; all state updates on the rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `m0_en`, `m0_wen`  in  1 each  master 0 address-phase request and write flag
- `m0_size`  in  `MEM_TYPE_WIDTH`  master 0 access size
- `m0_addr`  in  `XPR_LEN`  master 0 address
- `m0_wdata`  in  `XPR_LEN`  master 0 write data, valid during its data phase
- `m0_wait`  out  1  master 0 stall
- `m0_badmem_e`  out  1  master 0 access fault
- `m1_en`, `m1_wen`, `m1_size`, `m1_addr`, `m1_wdata`, `m1_wait`, `m1_badmem_e`: identical to the master 0 ports, for master 1
- `rdata`  out  `XPR_LEN`  read data, broadcast to both masters
- `s_en`, `s_wen`  out  1 each  slave request and write flag
- `s_size`  out  `MEM_TYPE_WIDTH`  slave access size
- `s_addr`  out  `XPR_LEN`  slave address
- `s_wdata`  out  `XPR_LEN`  slave write data
- `s_rdata`  in  `XPR_LEN`  slave read data
- `s_wait`  in  1  slave stall, applies to the current data phase
- `s_badmem_e`  in  1  slave fault

## Operation
- **State:**
  - `dp_valid`: a data phase is outstanding.
  - `dp_owner`: which master owns it.
  - `gnt_q`: the last grant.
  - `starve_cnt` (configurable, see below).
- **Ready:** `ready = ~(dp_valid & s_wait)`.
- **Grant selection, combinational:**
  - When `ready` is 0, the grant stays at `gnt_q`.
  - Otherwise master 0 wins if `m0_en` is asserted, unless the starvation rule forces master 1.
  - Master 1 wins when `m1_en` is asserted and master 0 is not selected.
  - With no request, the grant keeps `gnt_q`.
- **Slave address channel:** `s_en`, `s_wen`, `s_size` and `s_addr` are muxed from the granted master. `s_en` is forced to 0 when the granted master's `en` is low.
- **Acceptance:** a request is accepted on a rising edge where `s_en & ready`. On acceptance:
  - `dp_valid` is set to 1.
  - `dp_owner` is set to the grant.
- **Data-phase retirement:** on an edge where `ready` is true and no request is accepted, the outstanding data phase retires and `dp_valid` is cleared to 0.
- **Data-phase routing:**
  - `s_wdata` comes from `dp_owner`'s `wdata`, and is 0 when `dp_valid` is 0.
  - `rdata` equals `s_rdata`, unmodified.
  - `mX_badmem_e = s_badmem_e & dp_valid & (dp_owner == X)`.
- **Wait generation:** `mX_wait = (dp_valid & dp_owner==X & s_wait) | (mX_en & (~granted_X | ~ready))`.
  - A master waiting on its own data phase stalls, including while it presents its next request.
  - A master whose request is not granted stalls.
- **Simultaneous events:**
  - Both masters request while `ready`: master 0 wins and master 1 sees wait.
  - A master stalled by `s_wait` keeps its address stable.
  - The arbiter does not re-arbitrate until `ready`.
- **Reset:** assertion is asynchronous and applies even mid-transfer. It clears `dp_valid`, `starve_cnt`, and sets `gnt_q` to master 0.
  - An in-flight data phase is abandoned, and no wait or badmem is reported for it afterwards.
  - With all request inputs at 0, all outputs are 0.

## Timing
- Address path from the masters to the slave is combinational, with zero added latency.
- The data phase starts in the cycle after acceptance and lasts 1 + N cycles, where N is the number of cycles `s_wait` is held high.
- `rdata`, `s_wdata` and the badmem outputs are combinational from the inputs and the state.
- Throughput is one accepted access per cycle when `s_wait` is 0, including back-to-back accesses alternating between masters.

## Configuration
- **`VSCALE_DMEM_ARB_STARVE_EN` defined:**
  - `starve_cnt` is implemented, with width `$clog2(STARVE_MAX+1)`.
  - On each `ready` edge with `m1_en` asserted and master 0 granted, the counter increments, saturating at `STARVE_MAX`.
  - It clears when a master 1 request is accepted.
  - When `starve_cnt == STARVE_MAX` and `m1_en` is asserted, master 1 wins the next arbitration over master 0.
- **`VSCALE_DMEM_ARB_STARVE_EN` undefined:** master 0 has strict priority and no counter exists.

## Test plan
- **Reset:** hold `reset_n` = 0 with random inputs, then release with all `en` = 0 → all outputs 0 and `dp_valid` = 0.
- **Single master 0 access:** `m0` loads from 0x100 and `s_rdata` returns 0xDEADBEEF in the next cycle → `s_addr` = 0x100 in cycle 0, `rdata` = 0xDEADBEEF in cycle 1, `m0_wait` = 0 throughout.
- **Contention:** `m0` and `m1` request simultaneously at 0x10 and 0x20 → `s_addr` = 0x10, `m1_wait` = 1 for one cycle, then `s_addr` = 0x20.
- **Slave wait:** `m1` stores 0x55 and `s_wait` = 1 for 3 data-phase cycles while `m0` requests → `s_wdata` = 0x55 is held and `m0_wait` = `m1_wait` = 1 for 3 cycles. `m0` is accepted on the 4th cycle.
- **Starvation (macro on, `STARVE_MAX` = 8):** `m0_en` held at 1 continuously with `m1_en` = 1 → `m1` is granted on the 9th cycle, then `m0` resumes. With the macro off, `m1` is never granted.
- **Mid-transfer reset:** assert `reset_n` = 0 during an `m1` data phase with `s_wait` = 1 and `s_badmem_e` = 1 → `m1_wait` and `m1_badmem_e` drop to 0 immediately.
